// File: rtl/dp_op_sequencer.sv
// dp_op_sequencer: control-step sequencer for the Datapath register-transfer
// controls. Each request preloads up to NUM_PRELOAD registers through MDR and
// then runs the fetch/execute steps T0..T5. Binary ops load Y in T3. Unary ops
// (NEG/NOT) skip T3.
// Optional feature macro: DP_SEQ_T6_EN. When it is defined, a wide (MUL/DIV)
// request adds a T6 step that writes ZHI into HI.
module dp_op_sequencer #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned IDX_W       = 5,
  parameter int unsigned CTRL_W      = 4,
  parameter int unsigned NUM_PRELOAD = 3,
  parameter int unsigned SEL_MDR     = 21,
  parameter int unsigned SEL_PC      = 20,
  parameter int unsigned SEL_ZLO     = 19,
  parameter int unsigned SEL_ZHI     = 18,
  parameter int unsigned EN_MDR      = 21,
  parameter int unsigned EN_PC       = 20,
  parameter int unsigned EN_Y        = 22,
  parameter int unsigned EN_IR       = 23,
  parameter int unsigned EN_Z        = 24,
  parameter int unsigned EN_MAR      = 25,
  parameter int unsigned EN_HI       = 26
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          unary,
  input  logic                          wide,
  input  logic [3:0]                    preload_cnt,
  input  logic [NUM_PRELOAD*IDX_W-1:0]  preload_reg,
  input  logic [NUM_PRELOAD*DATA_W-1:0] preload_dat,
  input  logic [DATA_W-1:0]             instr_word,
  input  logic [IDX_W-1:0]              src_a,
  input  logic [IDX_W-1:0]              src_b,
  input  logic [IDX_W-1:0]              dst,
  input  logic [CTRL_W-1:0]             alu_ctrl,
  output logic [DATA_W-1:0]             mdata_out,
  output logic                          md_read,
  output logic [IDX_W-1:0]              bus_sel,
  output logic                          bus_vld,
  output logic [IDX_W-1:0]              en_idx,
  output logic                          en_vld,
  output logic                          pc_inc,
  output logic [CTRL_W-1:0]             ctrl_sig,
  output logic                          busy,
  output logic                          done
);

  localparam logic [IDX_W-1:0] B_MDR  = IDX_W'(SEL_MDR);
  localparam logic [IDX_W-1:0] B_PC   = IDX_W'(SEL_PC);
  localparam logic [IDX_W-1:0] B_ZLO  = IDX_W'(SEL_ZLO);
  localparam logic [IDX_W-1:0] E_MDR  = IDX_W'(EN_MDR);
  localparam logic [IDX_W-1:0] E_Y    = IDX_W'(EN_Y);
  localparam logic [IDX_W-1:0] E_IR   = IDX_W'(EN_IR);
  localparam logic [IDX_W-1:0] E_Z    = IDX_W'(EN_Z);
  localparam logic [IDX_W-1:0] E_MAR  = IDX_W'(EN_MAR);
`ifdef DP_SEQ_T6_EN
  localparam logic [IDX_W-1:0] B_ZHI  = IDX_W'(SEL_ZHI);
  localparam logic [IDX_W-1:0] E_HI   = IDX_W'(EN_HI);
`endif
  // No step drives EN_PC. It stays in the parameter list so that the index
  // map is complete.
  localparam int unsigned unused_idx_params = EN_PC + SEL_ZHI + EN_HI;

  typedef enum logic [3:0] {
    S_IDLE, S_LDA, S_LDB, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5,
`ifdef DP_SEQ_T6_EN
    S_T6,
`endif
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [3:0] k_q, k_d, cnt_q, cnt_d, cnt_clamp, k_inc;
  logic [NUM_PRELOAD*IDX_W-1:0]  reg_q, reg_d;
  logic [NUM_PRELOAD*DATA_W-1:0] dat_q, dat_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [IDX_W-1:0]  src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
  logic [CTRL_W-1:0] alu_q, alu_d;
  logic              unary_q, unary_d;
  logic              accept;

  logic [DATA_W-1:0] dat_slot;
  logic [IDX_W-1:0]  reg_slot;

  logic [DATA_W-1:0] mdata_d;
  logic [IDX_W-1:0]  bus_sel_d, en_idx_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic              md_read_d, bus_vld_d, en_vld_d, pc_inc_d, busy_d, done_d;

`ifdef DP_SEQ_T6_EN
  logic wide_q, wide_d;
`else
  logic unused_wide;
  assign unused_wide = wide;
`endif

  assign cnt_clamp = (32'(preload_cnt) > NUM_PRELOAD) ? 4'(NUM_PRELOAD) : preload_cnt;
  assign accept    = start && !abort && (state_q == S_IDLE || state_q == S_DONE);
  assign k_inc     = k_q + 4'd1;

  // Next-state, request capture and next registered output values.
  // The outputs are decoded from the *next* state and the *next* captured
  // request, so that the output flops show the new step on the same edge.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    reg_d     = reg_q;
    dat_d     = dat_q;
    instr_d   = instr_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    dst_d     = dst_q;
    alu_d     = alu_q;
    unary_d   = unary_q;
`ifdef DP_SEQ_T6_EN
    wide_d    = wide_q;
`endif
    dat_slot  = '0;
    reg_slot  = '0;
    mdata_d   = '0;
    md_read_d = 1'b0;
    bus_sel_d = '0;
    bus_vld_d = 1'b0;
    en_idx_d  = '0;
    en_vld_d  = 1'b0;
    pc_inc_d  = 1'b0;
    ctrl_d    = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else if (accept) begin
      cnt_d   = cnt_clamp;
      k_d     = '0;
      reg_d   = preload_reg;
      dat_d   = preload_dat;
      instr_d = instr_word;
      src_a_d = src_a;
      src_b_d = src_b;
      dst_d   = dst;
      alu_d   = alu_ctrl;
      unary_d = unary;
`ifdef DP_SEQ_T6_EN
      wide_d  = wide;
`endif
      state_d = (cnt_clamp == 4'd0) ? S_T0 : S_LDA;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_LDA:  state_d = S_LDB;
        S_LDB: begin
          k_d     = k_inc;
          state_d = (k_inc < cnt_q) ? S_LDA : S_T0;
        end
        S_T0:   state_d = S_T1;
        S_T1:   state_d = S_T2;
        S_T2:   state_d = unary_q ? S_T4 : S_T3;
        S_T3:   state_d = S_T4;
        S_T4:   state_d = S_T5;
`ifdef DP_SEQ_T6_EN
        S_T5:   state_d = wide_q ? S_T6 : S_DONE;
        S_T6:   state_d = S_DONE;
`else
        S_T5:   state_d = S_DONE;
`endif
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    for (int unsigned i = 0; i < NUM_PRELOAD; i++) begin
      if (32'(k_d) == i) begin
        dat_slot = dat_d[i*DATA_W +: DATA_W];
        reg_slot = reg_d[i*IDX_W +: IDX_W];
      end
    end

    unique case (state_d)
      S_LDA: begin
        mdata_d = dat_slot; md_read_d = 1'b1;
        en_idx_d = E_MDR; en_vld_d = 1'b1; busy_d = 1'b1;
      end
      S_LDB: begin
        bus_sel_d = B_MDR; bus_vld_d = 1'b1;
        en_idx_d = reg_slot; en_vld_d = 1'b1; busy_d = 1'b1;
      end
      S_T0: begin
        bus_sel_d = B_PC; bus_vld_d = 1'b1;
        en_idx_d = E_MAR; en_vld_d = 1'b1; pc_inc_d = 1'b1; busy_d = 1'b1;
      end
      S_T1: begin
        mdata_d = instr_d; md_read_d = 1'b1;
        en_idx_d = E_MDR; en_vld_d = 1'b1; busy_d = 1'b1;
      end
      S_T2: begin
        bus_sel_d = B_MDR; bus_vld_d = 1'b1;
        en_idx_d = E_IR; en_vld_d = 1'b1; busy_d = 1'b1;
      end
      S_T3: begin
        bus_sel_d = src_a_d; bus_vld_d = 1'b1;
        en_idx_d = E_Y; en_vld_d = 1'b1; busy_d = 1'b1;
      end
      S_T4: begin
        bus_sel_d = unary_d ? src_a_d : src_b_d; bus_vld_d = 1'b1;
        en_idx_d = E_Z; en_vld_d = 1'b1; ctrl_d = alu_d; busy_d = 1'b1;
      end
      S_T5: begin
        bus_sel_d = B_ZLO; bus_vld_d = 1'b1;
        en_idx_d = dst_d; en_vld_d = 1'b1; ctrl_d = alu_d; busy_d = 1'b1;
      end
`ifdef DP_SEQ_T6_EN
      S_T6: begin
        bus_sel_d = B_ZHI; bus_vld_d = 1'b1;
        en_idx_d = E_HI; en_vld_d = 1'b1; ctrl_d = alu_d; busy_d = 1'b1;
      end
`endif
      S_DONE: begin
        done_d = 1'b1; ctrl_d = alu_d;
      end
      default: ;
    endcase
  end

  // State register and preload slot counter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Request capture registers. They load only on the accepting edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q   <= '0;
      reg_q   <= '0;
      dat_q   <= '0;
      instr_q <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      alu_q   <= '0;
      unary_q <= 1'b0;
`ifdef DP_SEQ_T6_EN
      wide_q  <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      dat_q   <= dat_d;
      instr_q <= instr_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      dst_q   <= dst_d;
      alu_q   <= alu_d;
      unary_q <= unary_d;
`ifdef DP_SEQ_T6_EN
      wide_q  <= wide_d;
`endif
    end
  end

  // Registered Moore outputs. They clear asynchronously with clr.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mdata_out <= '0;
      md_read   <= 1'b0;
      bus_sel   <= '0;
      bus_vld   <= 1'b0;
      en_idx    <= '0;
      en_vld    <= 1'b0;
      pc_inc    <= 1'b0;
      ctrl_sig  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mdata_out <= mdata_d;
      md_read   <= md_read_d;
      bus_sel   <= bus_sel_d;
      bus_vld   <= bus_vld_d;
      en_idx    <= en_idx_d;
      en_vld    <= en_vld_d;
      pc_inc    <= pc_inc_d;
      ctrl_sig  <= ctrl_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_dp_op_sequencer.sv
// Table-driven bench for dp_op_sequencer. It also runs hand-written sequences
// for abort, back-to-back requests and mid-operation clr.
module tb_dp_op_sequencer;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 5;
  localparam int unsigned CW = 4;
  localparam int unsigned NP = 3;

  logic clk = 1'b0;
  logic clr, start, abort, unary, wide;
  logic [3:0]       preload_cnt;
  logic [NP*IW-1:0] preload_reg;
  logic [NP*DW-1:0] preload_dat;
  logic [DW-1:0]    instr_word;
  logic [IW-1:0]    src_a, src_b, dst;
  logic [CW-1:0]    alu_ctrl;
  logic [DW-1:0]    mdata_out;
  logic             md_read, bus_vld, en_vld, pc_inc, busy, done;
  logic [IW-1:0]    bus_sel, en_idx;
  logic [CW-1:0]    ctrl_sig;

  dp_op_sequencer #(.DATA_W(DW), .IDX_W(IW), .CTRL_W(CW), .NUM_PRELOAD(NP)) dut (
    .clk(clk), .clr(clr), .start(start), .abort(abort), .unary(unary), .wide(wide),
    .preload_cnt(preload_cnt), .preload_reg(preload_reg), .preload_dat(preload_dat),
    .instr_word(instr_word), .src_a(src_a), .src_b(src_b), .dst(dst), .alu_ctrl(alu_ctrl),
    .mdata_out(mdata_out), .md_read(md_read), .bus_sel(bus_sel), .bus_vld(bus_vld),
    .en_idx(en_idx), .en_vld(en_vld), .pc_inc(pc_inc), .ctrl_sig(ctrl_sig),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] md;
    logic          mrd;
    logic [IW-1:0] bus;
    logic          bvld;
    logic [IW-1:0] en;
    logic          evld;
    logic          pc;
    logic [CW-1:0] ctl;
    logic          bsy;
    logic          dn;
  } outs_t;

  typedef struct {
    string                 name;
    logic                  u;
    logic                  w;
    logic [3:0]            cnt;
    logic [NP-1:0][IW-1:0] r;
    logic [NP-1:0][DW-1:0] d;
    logic [DW-1:0]         instr;
    logic [IW-1:0]         a, b, dst;
    logic [CW-1:0]         ctrl;
    int                    exp_lat;
  } vec_t;

  int    n_vec  = 0;
  int    n_fail = 0;
  outs_t trace[$];
  outs_t ta[$];
  outs_t tbq[$];
  vec_t  vecs[7];

  function automatic vec_t mk(string nm, logic u, logic w, logic [3:0] c,
                              logic [IW-1:0] r0, logic [IW-1:0] r1, logic [IW-1:0] r2,
                              logic [DW-1:0] d0, logic [DW-1:0] d1, logic [DW-1:0] d2,
                              logic [DW-1:0] ins, logic [IW-1:0] a, logic [IW-1:0] b,
                              logic [IW-1:0] ds, logic [CW-1:0] ct, int lat);
    vec_t v;
    v.name = nm; v.u = u; v.w = w; v.cnt = c;
    v.r[0] = r0; v.r[1] = r1; v.r[2] = r2;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
    v.instr = ins; v.a = a; v.b = b; v.dst = ds; v.ctrl = ct; v.exp_lat = lat;
    return v;
  endfunction

  function automatic outs_t dut_out();
    outs_t o;
    o.md = mdata_out; o.mrd = md_read; o.bus = bus_sel; o.bvld = bus_vld;
    o.en = en_idx; o.evld = en_vld; o.pc = pc_inc; o.ctl = ctrl_sig;
    o.bsy = busy; o.dn = done;
    return o;
  endfunction

  function automatic string fmt(outs_t o);
    return $sformatf("md=%h mr=%b bus=%0d/%b en=%0d/%b pc=%b ctrl=%0d busy=%b done=%b",
                     o.md, o.mrd, o.bus, o.bvld, o.en, o.evld, o.pc, o.ctl, o.bsy, o.dn);
  endfunction

  task automatic check(input string nm, input outs_t exp);
    outs_t got;
    got = dut_out();
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %s | want %s", nm, fmt(got), fmt(exp));
    end
  endtask

  // Expected per-cycle outputs. Index 0 is the step entered on the accepting
  // edge. The last two entries are DONE and the following IDLE.
  task automatic build_trace(input vec_t v);
    outs_t o;
    int unsigned c;
    c = (v.cnt > 4'(NP)) ? NP : int'(v.cnt);
    trace.delete();
    for (int unsigned k = 0; k < c; k++) begin
      o = '0; o.md = v.d[k]; o.mrd = 1'b1; o.en = 5'd21; o.evld = 1'b1; o.bsy = 1'b1;
      trace.push_back(o);
      o = '0; o.bus = 5'd21; o.bvld = 1'b1; o.en = v.r[k]; o.evld = 1'b1; o.bsy = 1'b1;
      trace.push_back(o);
    end
    o = '0; o.bus = 5'd20; o.bvld = 1'b1; o.en = 5'd25; o.evld = 1'b1; o.pc = 1'b1; o.bsy = 1'b1;
    trace.push_back(o);
    o = '0; o.md = v.instr; o.mrd = 1'b1; o.en = 5'd21; o.evld = 1'b1; o.bsy = 1'b1;
    trace.push_back(o);
    o = '0; o.bus = 5'd21; o.bvld = 1'b1; o.en = 5'd23; o.evld = 1'b1; o.bsy = 1'b1;
    trace.push_back(o);
    if (!v.u) begin
      o = '0; o.bus = v.a; o.bvld = 1'b1; o.en = 5'd22; o.evld = 1'b1; o.bsy = 1'b1;
      trace.push_back(o);
    end
    o = '0; o.bus = v.u ? v.a : v.b; o.bvld = 1'b1; o.en = 5'd24; o.evld = 1'b1;
    o.ctl = v.ctrl; o.bsy = 1'b1;
    trace.push_back(o);
    o = '0; o.bus = 5'd19; o.bvld = 1'b1; o.en = v.dst; o.evld = 1'b1; o.ctl = v.ctrl; o.bsy = 1'b1;
    trace.push_back(o);
`ifdef DP_SEQ_T6_EN
    if (v.w) begin
      o = '0; o.bus = 5'd18; o.bvld = 1'b1; o.en = 5'd26; o.evld = 1'b1; o.ctl = v.ctrl; o.bsy = 1'b1;
      trace.push_back(o);
    end
`endif
    o = '0; o.dn = 1'b1; o.ctl = v.ctrl;
    trace.push_back(o);
    trace.push_back('0);
  endtask

  task automatic apply(input vec_t v);
    unary = v.u; wide = v.w; preload_cnt = v.cnt;
    preload_reg = v.r; preload_dat = v.d; instr_word = v.instr;
    src_a = v.a; src_b = v.b; dst = v.dst; alu_ctrl = v.ctrl;
  endtask

  // Inputs changed after the accepting edge must have no effect.
  task automatic scramble();
    unary = ~unary; wide = ~wide; preload_cnt = ~preload_cnt;
    preload_reg = ~preload_reg; preload_dat = ~preload_dat; instr_word = ~instr_word;
    src_a = ~src_a; src_b = ~src_b; dst = ~dst; alu_ctrl = ~alu_ctrl;
  endtask

  task automatic run_vec(input vec_t v);
    int done_at;
    int lat;
    done_at = -1;
    lat = v.exp_lat;
`ifdef DP_SEQ_T6_EN
    if (v.w) lat = lat + 1;
`endif
    build_trace(v);
    apply(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    for (int k = 0; k < trace.size(); k++) begin
      @(negedge clk);
      if (done === 1'b1 && done_at < 0) done_at = k;
      check($sformatf("%s c%0d", v.name, k), trace[k]);
    end
    n_vec++;
    if (done_at != lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", v.name, done_at, lat);
    end
  endtask

  task automatic expect_no_done(input string nm, input int cycles);
    logic saw;
    saw = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done !== 1'b0) saw = 1'b1;
    end
    n_vec++;
    if (saw) begin
      n_fail++;
      $display("FAIL %s: got done pulse want none", nm);
    end
  endtask

  initial begin
    vecs[0] = mk("neg_pre3",   1, 0, 4'd3,  5'd2,  5'd3,  5'd1,  32'h12, 32'h14, 32'h18,
                 32'h9008_0000, 5'd2, 5'd7, 5'd1, 4'd5, 11);
    vecs[1] = mk("bin_pre0",   0, 0, 4'd0,  5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0,
                 32'h00A1_B2C3, 5'd3, 5'd2, 5'd4, 4'd3, 6);
    vecs[2] = mk("bin_pre1",   0, 0, 4'd1,  5'd5,  5'd0,  5'd0,  32'hDEAD_BEEF, 32'h0, 32'h0,
                 32'h1357_9BDF, 5'd5, 5'd6, 5'd7, 4'd9, 8);
    vecs[3] = mk("not_clamp7", 1, 0, 4'd7,  5'd4,  5'd6,  5'd8,  32'h1111_1111, 32'h2222_2222,
                 32'h3333_3333, 32'h4800_0000, 5'd4, 5'd1, 5'd9, 4'hA, 11);
    vecs[4] = mk("wide_pre2",  0, 1, 4'd2,  5'd10, 5'd11, 5'd0,  32'hAAAA_5555, 32'h0F0F_0F0F,
                 32'h0, 32'h7000_0000, 5'd10, 5'd11, 5'd12, 4'hC, 10);
    vecs[5] = mk("unary_pre0", 1, 0, 4'd0,  5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0,
                 32'h8800_0000, 5'd6, 5'd0, 5'd3, 4'd1, 5);
    vecs[6] = mk("bin_clamp15", 0, 0, 4'd15, 5'd13, 5'd14, 5'd15, 32'h1, 32'h2, 32'h3,
                 32'hCAFE_F00D, 5'd13, 5'd14, 5'd15, 4'hF, 12);

    clr = 1'b0; start = 1'b0; abort = 1'b0;
    apply(vecs[0]);
    repeat (2) @(negedge clk);
    check("reset", '0);
    clr = 1'b1;
    @(negedge clk);
    check("idle_after_reset", '0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Abort during T2: the next edge returns to IDLE with no done pulse.
    build_trace(vecs[1]);
    apply(vecs[1]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_pre c%0d", k), trace[k]);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle", '0);
    expect_no_done("abort_no_done", 8);
    run_vec(vecs[1]);

    // Back-to-back requests: start is held through DONE, and a start pulse
    // while busy is ignored.
    build_trace(vecs[1]); ta = trace;
    build_trace(vecs[5]); tbq = trace;
    apply(vecs[1]);
    start = 1'b1;
    @(posedge clk); #1;
    apply(vecs[5]);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("b2b_a c%0d", k), ta[k]);
    end
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    for (int k = 0; k < tbq.size(); k++) begin
      @(negedge clk);
      check($sformatf("b2b_b c%0d", k), tbq[k]);
      if (k == 1) start = 1'b1;
      if (k == 2) start = 1'b0;
    end

    // clr dropped mid-LDB(1): outputs clear before the next edge.
    build_trace(vecs[0]);
    apply(vecs[0]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("clr_pre c%0d", k), trace[k]);
    end
    #2 clr = 1'b0;
    #1 check("clr_async", '0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("clr_idle", '0);
    expect_no_done("clr_no_done", 6);
    run_vec(vecs[2]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
